// File: rtl/xintf_cmd_scan.sv
// Periodic scanner of the XINTF write DPBRAM: snapshots the command block and
// publishes it atomically when the DSP commit word changes and no tear occurred.
module xintf_cmd_scan #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_scan_en,
    output logic [ADDR_W-1:0]            o_ram_addr,
    output logic                         o_ram_ce,
    output logic                         o_ram_we,
    output logic [DATA_W-1:0]            o_ram_din,
    input  logic [DATA_W-1:0]            i_ram_dout,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic [DATA_W-1:0]            o_commit,
    output logic                         o_upd,
    output logic                         o_scan_done,
    output logic [7:0]                   o_tear_cnt,
    output logic                         o_busy
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMIT,
        S_CHK,
        S_READ,
        S_DRAIN,
        S_RECHK,
        S_APPLY
    } state_t;

    state_t                             state_q;
    logic [DIV_W-1:0]                   div_q, div_d;
    logic [IDX_W-1:0]                   idx_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]    shadow_q;
    logic [DATA_W-1:0]                  new_commit_q;
    logic [DATA_W-1:0]                  rechk_q;
    logic [NUM_REGS*DATA_W-1:0]         regs_q;
    logic [DATA_W-1:0]                  commit_q;
    logic                               upd_q;
    logic                               done_q;
    logic [7:0]                         tear_q;
    logic                               busy_q;
    logic                               ce_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic                               tick_c;

    // Free-running scan divider, held at zero while scanning is disabled
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (!i_scan_en || div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Ticks that land while a scan is running are simply lost
    assign tick_c = i_scan_en && (div_q == DIV_W'(SCAN_DIV - 1)) && (state_q == S_IDLE);

    // Scan sequencer; RAM reads return data one cycle after ce/addr
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            new_commit_q <= '0;
            rechk_q      <= '0;
            regs_q       <= '0;
            commit_q     <= '0;
            upd_q        <= 1'b0;
            done_q       <= 1'b0;
            tear_q       <= '0;
            busy_q       <= 1'b0;
            ce_q         <= 1'b0;
            addr_q       <= '0;
        end else begin
            upd_q  <= 1'b0;
            done_q <= 1'b0;
            ce_q   <= 1'b0;
            addr_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (tick_c) begin
                        state_q <= S_COMMIT;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b1;
                        addr_q  <= ADDR_W'(NUM_REGS);
                    end
                end
                S_COMMIT: begin
                    state_q <= S_CHK;
                end
                S_CHK: begin
                    if (i_ram_dout == commit_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        new_commit_q <= i_ram_dout;
                        idx_q        <= '0;
                        ce_q         <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    // idx_q is the address on the bus; data for idx_q-1 arrives now
                    if (idx_q != '0) begin
                        shadow_q[idx_q - IDX_W'(1)] <= i_ram_dout;
                    end
                    ce_q <= 1'b1;
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        addr_q  <= ADDR_W'(NUM_REGS);
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= ADDR_W'(idx_q) + ADDR_W'(1);
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    shadow_q[IDX_W'(NUM_REGS - 1)] <= i_ram_dout;
                    state_q <= S_RECHK;
                end
                S_RECHK: begin
                    rechk_q <= i_ram_dout;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    if (rechk_q == new_commit_q) begin
                        regs_q   <= shadow_q;
                        commit_q <= new_commit_q;
                        upd_q    <= 1'b1;
                    end else if (tear_q != 8'hFF) begin
                        tear_q <= tear_q + 8'd1;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ram_addr  = addr_q;
    assign o_ram_ce    = ce_q;
    assign o_ram_we    = 1'b0;
    assign o_ram_din   = '0;
    assign o_regs      = regs_q;
    assign o_commit    = commit_q;
    assign o_upd       = upd_q;
    assign o_scan_done = done_q;
    assign o_tear_cnt  = tear_q;
    assign o_busy      = busy_q;

endmodule
